// File: rtl/edc_pkg.sv
// Shared types and constants for the scrubbing EDC controller.
// FSM encoding and error-counter saturation helper.
package edc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        MERGE,
        WR,
        RESP
    } state_t;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/edcc_mod.sv
// Combinational corrector for duplicated-word ECC.
// The main word is trusted; any disagreement with its copy is an error.
module edcc_mod #(
    parameter int WB_DWIDTH = 32
) (
    input  logic [WB_DWIDTH-1:0] i_data,
    input  logic [WB_DWIDTH-1:0] i_ecc,
    output logic [WB_DWIDTH-1:0] o_data,
    output logic                 o_err
);

    assign o_data = i_data;
    assign o_err  = (i_data != i_ecc);

endmodule

// File: rtl/edc_scrub_ctrl.sv
// Memory access controller with duplicated-word error checking,
// read-modify-write for partial writes and optional scrub write-back.
module edc_scrub_ctrl
    import edc_pkg::*;
#(
    parameter int WB_DWIDTH = 32,
    parameter int WB_SWIDTH = 4,
    parameter int SCRUB_EN  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [31:0]          i_addr,
    input  logic [WB_DWIDTH-1:0] i_wdata,
    input  logic [WB_SWIDTH-1:0] i_sel,
    output logic                 o_ack,
    output logic [WB_DWIDTH-1:0] o_rdata,
    output logic                 o_err,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [31:0]          o_mem_addr,
    output logic [WB_DWIDTH-1:0] o_mem_wdata,
    output logic [WB_DWIDTH-1:0] o_mem_ecc_wdata,
    input  logic                 i_mem_ack,
    input  logic [WB_DWIDTH-1:0] i_mem_rdata,
    input  logic [WB_DWIDTH-1:0] i_mem_ecc_rdata,
    output logic [15:0]          o_err_cnt
);

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [WB_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [WB_SWIDTH-1:0]   sel_q, sel_d;
    logic [WB_DWIDTH-1:0]   mrd_q, mrd_d;
    logic [WB_DWIDTH-1:0]   mecc_q, mecc_d;
    logic [WB_DWIDTH-1:0]   corr_q, corr_d;
    logic                   err_q, err_d;
    logic [WB_DWIDTH-1:0]   word_q, word_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [WB_DWIDTH-1:0]   edc_data;
    logic                   edc_err;

    edcc_mod #(
        .WB_DWIDTH (WB_DWIDTH)
    ) u_edcc (
        .i_data (mrd_q),
        .i_ecc  (mecc_q),
        .o_data (edc_data),
        .o_err  (edc_err)
    );

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            mrd_q   <= '0;
            mecc_q  <= '0;
            corr_q  <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            mrd_q   <= mrd_d;
            mecc_q  <= mecc_d;
            corr_q  <= corr_d;
            err_q   <= err_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath updates for each access phase.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        mrd_d   = mrd_q;
        mecc_d  = mecc_q;
        corr_d  = corr_q;
        err_d   = err_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    we_d    = i_we;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    sel_d   = i_sel;
                    word_d  = i_wdata;
                    corr_d  = '0;
                    err_d   = 1'b0;
                    if (i_we && (&i_sel)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (i_mem_ack) begin
                    mrd_d   = i_mem_rdata;
                    mecc_d  = i_mem_ecc_rdata;
                    state_d = CHK;
                end
            end
            CHK: begin
                corr_d = edc_data;
                err_d  = edc_err;
                if (edc_err) begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (we_q) begin
                    state_d = MERGE;
                end else if (edc_err && (SCRUB_EN != 0)) begin
                    word_d  = edc_data;
                    state_d = WR;
                end else begin
                    state_d = RESP;
                end
            end
            MERGE: begin
                for (int b = 0; b < WB_SWIDTH; b++) begin
                    word_d[8*b +: 8] = sel_q[b] ? wdata_q[8*b +: 8]
                                                : corr_q[8*b +: 8];
                end
                state_d = WR;
            end
            WR: begin
                if (i_mem_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; stable while requesting.
    always_comb begin
        o_mem_req       = (state_q == RD) || (state_q == WR);
        o_mem_we        = (state_q == WR);
        o_mem_addr      = addr_q;
        o_mem_wdata     = word_q;
        o_mem_ecc_wdata = word_q;
        o_ack           = (state_q == RESP);
        o_rdata         = ((state_q == RESP) && !we_q) ? corr_q : '0;
        o_err           = (state_q == RESP) && err_q;
        o_err_cnt       = cnt_q;
    end

endmodule
